cmp_monitor: RTL

Debounced result tracker that sits directly downstream of the 4-bit magnitude comparator and consumes its g/e/l outputs. It turns the raw per-sample comparison result into a stable, filtered relation state (BELOW/EQUAL/ABOVE). It emits single-cycle crossing events and keeps saturating crossing counters. It also flags illegal comparator codes, meaning samples where the code is not exactly one of g/e/l.

---
 rtl/cmp_monitor_if.sv | 27 ++
 rtl/cmp_monitor.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cmp_monitor_if.sv
// Bundle of comparator sample inputs and filtered relation outputs between
// the comparator-side driver and the debounced result tracker.
interface cmp_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             g;
    logic             e;
    logic             l;
    logic             clear;
    logic [1:0]       state;
    logic             rise_evt;
    logic             fall_evt;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] down_cnt;
    logic             err;

    modport master (
        output in_valid, g, e, l, clear,
        input  state, rise_evt, fall_evt, up_cnt, down_cnt, err
    );

    modport slave (
        input  in_valid, g, e, l, clear,
        output state, rise_evt, fall_evt, up_cnt, down_cnt, err
    );
endinterface

// File: rtl/cmp_monitor.sv
// Debounced tracker for the g/e/l outputs of a magnitude comparator.
// Filters raw samples into a stable BELOW/EQUAL/ABOVE relation, pulses on
// crossings, keeps saturating crossing counters and a sticky illegal-code flag.
module cmp_monitor #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_monitor_if.slave  mon
);
    localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        REL_UNKNOWN = 2'b00,
        REL_BELOW   = 2'b01,
        REL_EQUAL   = 2'b10,
        REL_ABOVE   = 2'b11
    } rel_t;

    rel_t             state_q, state_d;
    rel_t             cand_q, cand_d;
    rel_t             sample_code;
    logic             sample_legal;
    logic [RUN_W-1:0] run_q, run_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] up_q, up_d;
    logic [CNT_W-1:0] down_q, down_d;
    logic             err_q, err_d;

    // Decode the one-hot comparator result; anything not exactly one-hot is illegal.
    always_comb begin
        sample_legal = 1'b1;
        sample_code  = REL_UNKNOWN;
        case ({mon.g, mon.e, mon.l})
            3'b001:  sample_code = REL_BELOW;
            3'b010:  sample_code = REL_EQUAL;
            3'b100:  sample_code = REL_ABOVE;
            default: sample_legal = 1'b0;
        endcase
    end

    // Next-state: run tracking, state qualification, crossing events and counters.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        up_d    = up_q;
        down_d  = down_q;
        err_d   = err_q;

        if (mon.in_valid) begin
            if (sample_legal) begin
                if (sample_code == cand_q) begin
                    run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 1'b1;
                end else begin
                    cand_d = sample_code;
                    run_d  = RUN_W'(1);
                end

                if ((run_d == RUN_MAX) && (cand_d != state_q)) begin
                    state_d = cand_d;
                    if (state_q != REL_UNKNOWN) begin
                        if (cand_d > state_q) begin
                            rise_d = 1'b1;
                            if (up_q != CNT_MAX) begin
                                up_d = up_q + 1'b1;
                            end
                        end else begin
                            fall_d = 1'b1;
                            if (down_q != CNT_MAX) begin
                                down_d = down_q + 1'b1;
                            end
                        end
                    end
                end
            end else begin
                run_d = '0;
                err_d = 1'b1;
            end
        end

        if (mon.clear) begin
            up_d   = '0;
            down_d = '0;
            err_d  = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REL_UNKNOWN;
            cand_q  <= REL_UNKNOWN;
            run_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            up_q    <= '0;
            down_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
        end
    end

    assign mon.state    = state_q;
    assign mon.rise_evt = rise_q;
    assign mon.fall_evt = fall_q;
    assign mon.up_cnt   = up_q;
    assign mon.down_cnt = down_q;
    assign mon.err      = err_q;
endmodule
